// File: rtl/l1_ld_resp.sv
// l1_ld_resp -- load-side responder for the page-walk unit's L1 interface.
//
// Services one walker load at a time: looks the word address up in a small
// direct-mapped word cache, refills misses over a single-beat memory read
// channel, and returns the 32-bit word with a valid. A cancel arriving while
// the request is in LOOKUP completes the load with a zero response and no
// refill. The response is held for as long as stall_i is asserted.
//
// Configuration macro: L1R_CACHE_EN
//   defined   -> tag/data array present, hits return in 2 cycles.
//   undefined -> no storage; every non-cancelled load is refilled from memory.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   l1_va_i/_vld_i        load word address and valid from the walker
//   l1_cancel_i           cancel for the request currently in LOOKUP
//   stall_i               external stall, holds the response
//   l1_pa_o/l1_vld_o      returned word and response valid (registered)
//   mem_addr_o/mem_req_o  refill address and request (registered)
//   mem_gnt_i             refill request accepted
//   mem_rdata_i/_rvld_i   refill data and its single-beat valid

module l1_ld_resp #(
  parameter int unsigned LINES = 16,
  parameter int unsigned IDX_W = $clog2(LINES)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [27:0] l1_va_i,
  input  logic        l1_va_vld_i,
  input  logic        l1_cancel_i,
  input  logic        stall_i,
  output logic [31:0] l1_pa_o,
  output logic        l1_vld_o,
  output logic [27:0] mem_addr_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_rvld_i
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MISS_REQ,
    ST_MISS_WAIT,
    ST_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [25:0] addr_q, addr_d;     // word address, byte offset dropped
  logic [31:0] pa_q, pa_d;         // doubles as the response data register
  logic        vld_q, vld_d;
  logic        req_q, req_d;
  logic [27:0] maddr_q, maddr_d;

  logic        hit;
  logic [31:0] hit_data;
  logic        fill;

  // Byte offset never takes part in lookup or refill addressing.
  logic unused_lsb;
  assign unused_lsb = ^l1_va_i[1:0];

  assign fill = (state_q == ST_MISS_WAIT) && mem_rvld_i && !rst_i;

`ifdef L1R_CACHE_EN
  localparam int unsigned TAG_W = 26 - IDX_W;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;

  assign idx      = addr_q[IDX_W-1:0];
  assign tag      = addr_q[25:IDX_W];
  assign hit      = valid_q[idx] && (tag_q[idx] == tag);
  assign hit_data = data_q[idx];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (fill) begin
      valid_q[idx] <= 1'b1;
    end
  end

  // Tag/data need no reset: they are qualified by valid_q.
  always_ff @(posedge clk_i) begin
    if (fill) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= mem_rdata_i;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;

  logic [IDX_W-1:0] unused_idx;
  assign unused_idx = addr_q[IDX_W-1:0];
`endif

  // Output registers are loaded on the transition into the state that owns
  // them, so every output is a flop yet tracks the state with no extra delay.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pa_d    = pa_q;
    maddr_d = maddr_q;
    vld_d   = 1'b0;
    req_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (l1_va_vld_i) begin
          addr_d  = l1_va_i[27:2];
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (l1_cancel_i) begin
          pa_d    = '0;
          vld_d   = 1'b1;
          state_d = ST_RESP;
        end else if (hit) begin
          pa_d    = hit_data;
          vld_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          maddr_d = {addr_q, 2'b00};
          req_d   = 1'b1;
          state_d = ST_MISS_REQ;
        end
      end
      ST_MISS_REQ: begin
        if (mem_gnt_i) begin
          state_d = ST_MISS_WAIT;
        end else begin
          req_d = 1'b1;
        end
      end
      ST_MISS_WAIT: begin
        if (mem_rvld_i) begin
          pa_d    = mem_rdata_i;
          vld_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (stall_i) begin
          vld_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      pa_q    <= '0;
      vld_q   <= 1'b0;
      req_q   <= 1'b0;
      maddr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pa_q    <= pa_d;
      vld_q   <= vld_d;
      req_q   <= req_d;
      maddr_q <= maddr_d;
    end
  end

  assign l1_pa_o    = pa_q;
  assign l1_vld_o   = vld_q;
  assign mem_addr_o = maddr_q;
  assign mem_req_o  = req_q;

endmodule
